// File: rtl/hall_req_bank.sv
// hall_req_bank
// Bank of hall-call request registers, one up/down pair per floor.
// Each floor's pulsed push button steps its request OFF -> UP -> DN -> BOTH
// (end floors allow only their single legal direction). The lift controller
// clears requests per floor and direction. Also provides aggregated demand
// relative to the current floor and per-floor ageing with an oldest pointer.
//
// Ports:
//   clk, resetb            clock, asynchronous active-low reset
//   slowref                tick enable; state only advances when high
//   hall_en                accept new presses (clears always honoured)
//   pbpulse[NFLOORS]       per-floor button press pulse
//   clrup/clrdn[NFLOORS]   per-floor clear of UP / DOWN request
//   curfloor[FW]           current lift floor
//   upreq/dnreq[NFLOORS]   registered per-floor requests
//   req_above/req_below    any request above / below curfloor
//   req_here_up/_dn        request at curfloor
//   stale[NFLOORS]         per-floor age counter saturated
//   oldest_vld/_floor      oldest pending floor (ties to lowest index)
module hall_req_bank #(
  parameter int NFLOORS = 4,
  parameter int FW      = 2,
  parameter int AGEW    = 8
) (
  input  logic               clk,
  input  logic               resetb,
  input  logic               slowref,
  input  logic               hall_en,
  input  logic [NFLOORS-1:0] pbpulse,
  input  logic [NFLOORS-1:0] clrup,
  input  logic [NFLOORS-1:0] clrdn,
  input  logic [FW-1:0]      curfloor,
  output logic [NFLOORS-1:0] upreq,
  output logic [NFLOORS-1:0] dnreq,
  output logic               req_above,
  output logic               req_below,
  output logic               req_here_up,
  output logic               req_here_dn,
  output logic [NFLOORS-1:0] stale,
  output logic               oldest_vld,
  output logic [FW-1:0]      oldest_floor
);

  localparam logic [AGEW-1:0] AGE_MAX = '1;

  logic [NFLOORS-1:0] up_q, up_d;
  logic [NFLOORS-1:0] dn_q, dn_d;
  logic [AGEW-1:0]    age_q [NFLOORS];
  logic [AGEW-1:0]    age_d [NFLOORS];
  logic [AGEW-1:0]    best_age;

  // Next-state logic: illegal encodings fall back to OFF, then clears take
  // priority over a press on the same floor.
  always_comb begin
    up_d = up_q;
    dn_d = dn_q;
    for (int f = 0; f < NFLOORS; f++) begin
      age_d[f] = age_q[f];
    end
    if (slowref) begin
      for (int f = 0; f < NFLOORS; f++) begin
        if ((f == 0 && dn_q[f]) || (f == NFLOORS-1 && up_q[f])) begin
          up_d[f] = 1'b0;
          dn_d[f] = 1'b0;
        end else if (clrup[f] || clrdn[f]) begin
          up_d[f] = up_q[f] & ~clrup[f];
          dn_d[f] = dn_q[f] & ~clrdn[f];
        end else if (hall_en && pbpulse[f]) begin
          if (f == 0) begin
            up_d[f] = 1'b1;
            dn_d[f] = 1'b0;
          end else if (f == NFLOORS-1) begin
            up_d[f] = 1'b0;
            dn_d[f] = 1'b1;
          end else if (!up_q[f] && !dn_q[f]) begin
            up_d[f] = 1'b1;
            dn_d[f] = 1'b0;
          end else if (up_q[f] && !dn_q[f]) begin
            up_d[f] = 1'b0;
            dn_d[f] = 1'b1;
          end else begin
            up_d[f] = 1'b1;
            dn_d[f] = 1'b1;
          end
        end
        // Age only grows while the floor was already pending; a floor
        // leaving OFF or returning to OFF sits at zero.
        if (!(up_d[f] || dn_d[f])) begin
          age_d[f] = '0;
        end else if (up_q[f] || dn_q[f]) begin
          age_d[f] = (age_q[f] == AGE_MAX) ? AGE_MAX : age_q[f] + AGEW'(1);
        end else begin
          age_d[f] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      up_q <= '0;
      dn_q <= '0;
      for (int f = 0; f < NFLOORS; f++) begin
        age_q[f] <= '0;
      end
    end else begin
      up_q <= up_d;
      dn_q <= dn_d;
      for (int f = 0; f < NFLOORS; f++) begin
        age_q[f] <= age_d[f];
      end
    end
  end

  assign upreq = up_q;
  assign dnreq = dn_q;

  // Demand relative to curfloor; an out-of-range curfloor reports nothing.
  always_comb begin
    req_above   = 1'b0;
    req_below   = 1'b0;
    req_here_up = 1'b0;
    req_here_dn = 1'b0;
    if (int'(curfloor) < NFLOORS) begin
      for (int f = 0; f < NFLOORS; f++) begin
        if (up_q[f] || dn_q[f]) begin
          if (f > int'(curfloor)) req_above = 1'b1;
          if (f < int'(curfloor)) req_below = 1'b1;
        end
        if (f == int'(curfloor)) begin
          req_here_up = up_q[f];
          req_here_dn = dn_q[f];
        end
      end
    end
  end

  // Oldest pending floor; strict comparison keeps ties on the lowest index.
  always_comb begin
    oldest_vld   = 1'b0;
    oldest_floor = '0;
    best_age     = '0;
    for (int f = 0; f < NFLOORS; f++) begin
      stale[f] = (age_q[f] == AGE_MAX);
      if ((up_q[f] || dn_q[f]) && (!oldest_vld || age_q[f] > best_age)) begin
        oldest_vld   = 1'b1;
        oldest_floor = FW'(f);
        best_age     = age_q[f];
      end
    end
  end

endmodule

// File: tb/tb_hall_req_bank.sv
// tb_hall_req_bank
// Directed self-checking bench for hall_req_bank (NFLOORS=4, FW=3, AGEW=3).
// A behavioural model predicts outputs; expectations are queued when a step
// is driven and compared once the DUT has produced the result.
module tb_hall_req_bank;

  localparam int N    = 4;
  localparam int FW   = 3;
  localparam int AGEW = 3;
  localparam int AMAX = 7;

  logic          clk;
  logic          resetb;
  logic          slowref;
  logic          hall_en;
  logic [N-1:0]  pbpulse;
  logic [N-1:0]  clrup;
  logic [N-1:0]  clrdn;
  logic [FW-1:0] curfloor;
  logic [N-1:0]  upreq;
  logic [N-1:0]  dnreq;
  logic          req_above;
  logic          req_below;
  logic          req_here_up;
  logic          req_here_dn;
  logic [N-1:0]  stale;
  logic          oldest_vld;
  logic [FW-1:0] oldest_floor;

  hall_req_bank #(.NFLOORS(N), .FW(FW), .AGEW(AGEW)) dut (
    .clk(clk), .resetb(resetb), .slowref(slowref), .hall_en(hall_en),
    .pbpulse(pbpulse), .clrup(clrup), .clrdn(clrdn), .curfloor(curfloor),
    .upreq(upreq), .dnreq(dnreq), .req_above(req_above), .req_below(req_below),
    .req_here_up(req_here_up), .req_here_dn(req_here_dn), .stale(stale),
    .oldest_vld(oldest_vld), .oldest_floor(oldest_floor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  up;
    logic [N-1:0]  dn;
    logic [N-1:0]  stl;
    logic          ovld;
    logic [FW-1:0] ofl;
    logic          above;
    logic          below;
    logic          hup;
    logic          hdn;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  logic mUp [N];
  logic mDn [N];
  int   mAge[N];

  task automatic modelReset();
    for (int f = 0; f < N; f++) begin
      mUp[f] = 1'b0; mDn[f] = 1'b0; mAge[f] = 0;
    end
  endtask

  // One slowref tick of the reference behaviour.
  task automatic modelTick(input logic [N-1:0] pb, input logic [N-1:0] cu,
                           input logic [N-1:0] cd, input logic en);
    logic nu, nd;
    for (int f = 0; f < N; f++) begin
      nu = mUp[f]; nd = mDn[f];
      if (cu[f] || cd[f]) begin
        if (cu[f]) nu = 1'b0;
        if (cd[f]) nd = 1'b0;
      end else if (en && pb[f]) begin
        if (f == 0) begin nu = 1'b1; nd = 1'b0; end
        else if (f == N-1) begin nu = 1'b0; nd = 1'b1; end
        else begin
          case ({mUp[f], mDn[f]})
            2'b00:   begin nu = 1'b1; nd = 1'b0; end
            2'b10:   begin nu = 1'b0; nd = 1'b1; end
            default: begin nu = 1'b1; nd = 1'b1; end
          endcase
        end
      end
      if (!nu && !nd) mAge[f] = 0;
      else if (mUp[f] || mDn[f]) mAge[f] = (mAge[f] >= AMAX) ? AMAX : mAge[f] + 1;
      else mAge[f] = 0;
      mUp[f] = nu; mDn[f] = nd;
    end
  endtask

  function automatic exp_t modelOutputs();
    exp_t e;
    int cf;
    int best;
    cf = int'(curfloor);
    e.ovld = 1'b0; e.ofl = '0; e.above = 1'b0; e.below = 1'b0;
    e.hup = 1'b0; e.hdn = 1'b0;
    best = -1;
    for (int f = 0; f < N; f++) begin
      e.up[f]  = mUp[f];
      e.dn[f]  = mDn[f];
      e.stl[f] = (mAge[f] == AMAX);
      if (mUp[f] || mDn[f]) begin
        if (mAge[f] > best) begin
          best = mAge[f]; e.ovld = 1'b1; e.ofl = FW'(f);
        end
        if (cf < N && f > cf) e.above = 1'b1;
        if (cf < N && f < cf) e.below = 1'b1;
      end
      if (cf == f) begin
        e.hup = mUp[f]; e.hdn = mDn[f];
      end
    end
    return e;
  endfunction

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exv);
    checks++;
    assert (obs === exv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exv);
    end
  endtask

  task automatic checkOutput(input string step);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s scoreboard empty observed=0 expected=1", step);
    end else begin
      e = sbq.pop_front();
      cmp({step, ".upreq"},        8'(upreq),        8'(e.up));
      cmp({step, ".dnreq"},        8'(dnreq),        8'(e.dn));
      cmp({step, ".stale"},        8'(stale),        8'(e.stl));
      cmp({step, ".oldest_vld"},   8'(oldest_vld),   8'(e.ovld));
      cmp({step, ".oldest_floor"}, 8'(oldest_floor), 8'(e.ofl));
      cmp({step, ".req_above"},    8'(req_above),    8'(e.above));
      cmp({step, ".req_below"},    8'(req_below),    8'(e.below));
      cmp({step, ".req_here_up"},  8'(req_here_up),  8'(e.hup));
      cmp({step, ".req_here_dn"},  8'(req_here_dn),  8'(e.hdn));
    end
  endtask

  // Drive one clock of stimulus, queue the prediction, check after the edge.
  task automatic applyStimulus(input string step, input logic [N-1:0] pb,
                               input logic [N-1:0] cu, input logic [N-1:0] cd,
                               input logic en, input logic sref);
    pbpulse = pb; clrup = cu; clrdn = cd; hall_en = en; slowref = sref;
    if (sref) modelTick(pb, cu, cd, en);
    sbq.push_back(modelOutputs());
    @(posedge clk);
    #1;
    pbpulse = '0; clrup = '0; clrdn = '0; slowref = 1'b0; hall_en = 1'b1;
    checkOutput(step);
  endtask

  // Combinational check with no clock tick (e.g. after a curfloor change).
  task automatic checkNow(input string step);
    sbq.push_back(modelOutputs());
    #1;
    checkOutput(step);
  endtask

  initial begin
    resetb = 1'b0; slowref = 1'b0; hall_en = 1'b1;
    pbpulse = '0; clrup = '0; clrdn = '0; curfloor = '0;
    modelReset();
    @(posedge clk);
    #1;
    checkNow("reset");
    resetb = 1'b1;

    // Middle floor press cycling: UP, DN, BOTH, BOTH
    applyStimulus("cyc1", 4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b1);
    applyStimulus("cyc2", 4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b1);
    applyStimulus("cyc3", 4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b1);
    applyStimulus("cyc4", 4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b1);
    applyStimulus("clr1", 4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b1);

    // End floors only ever take their single direction
    for (int i = 0; i < 3; i++) applyStimulus("bot", 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus("top", 4'b1000, 4'b0000, 4'b0000, 1'b1, 1'b1);
    applyStimulus("clr2", 4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b1);

    // Clear precedence on floor 2
    for (int i = 0; i < 3; i++) applyStimulus("f2both", 4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b1);
    applyStimulus("clrboth_press", 4'b0100, 4'b0100, 4'b0100, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus("f2both_b", 4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b1);
    applyStimulus("clrup_only", 4'b0000, 4'b0100, 4'b0000, 1'b1, 1'b1);
    applyStimulus("dn_to_both", 4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b1);
    applyStimulus("clrdn_only", 4'b0000, 4'b0000, 4'b0100, 1'b1, 1'b1);
    applyStimulus("no_slowref", 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0);
    applyStimulus("clr3", 4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b1);

    // Aggregates around curfloor, including an out-of-range floor
    curfloor = 3'd1;
    applyStimulus("agg_set", 4'b1001, 4'b0000, 4'b0000, 1'b1, 1'b1);
    checkNow("agg_cf1");
    curfloor = 3'd5;
    checkNow("agg_cf5");
    curfloor = 3'd3;
    checkNow("agg_cf3");
    curfloor = 3'd0;
    checkNow("agg_cf0");
    applyStimulus("clr4", 4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b1);

    // Ageing, saturation and oldest pointer
    applyStimulus("age_f2", 4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus("age_idle", 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1);
    applyStimulus("age_f1", 4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus("age_sat", 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1);
    applyStimulus("age_clr2", 4'b0000, 4'b0100, 4'b0100, 1'b1, 1'b1);
    applyStimulus("clr5", 4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b1);

    // Presses ignored while disabled
    applyStimulus("hall_dis", 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1);

    // Asynchronous reset in the middle of activity
    applyStimulus("pre_rst_a", 4'b0110, 4'b0000, 4'b0000, 1'b1, 1'b1);
    applyStimulus("pre_rst_b", 4'b1110, 4'b0000, 4'b0000, 1'b1, 1'b1);
    #2;
    resetb = 1'b0;
    modelReset();
    checkNow("async_rst");
    @(posedge clk);
    #1;
    resetb = 1'b1;
    applyStimulus("post_rst", 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hall_req_bank.md
# hall_req_bank

Parametrised bank of hall-call request registers for an NFLOORS-level lift, one up/down request pair per floor. Each floor's debounced, pulsed push button cycles its request through OFF -> UP -> DN -> BOTH, with the end floors restricted to a single legal direction. The lift state machine clears requests per floor and direction. The block also provides aggregated demand (above, below, at the current floor) and per-floor request ageing with an oldest-request pointer for the dispatcher.

## Interface
- NFLOORS, 4 — number of floors; minimum 2; floor 0 is bottom, floor NFLOORS-1 is top.
- FW, 2 — width of floor indices; must satisfy 2^FW >= NFLOORS.
- AGEW, 8 — width of each per-floor age counter; AGE_MAX = 2^AGEW-1.

Ports:
- clk  in  1  system clock.
- resetb  in  1  reset, asynchronous, active-low.
- slowref  in  1  single-cycle tick enable; all request and age state advances only in cycles where slowref=1.
- hall_en  in  1  1 = accept new button presses; 0 = presses ignored, clears still honoured.
- pbpulse  in  NFLOORS  per-floor pulsed button press; bit f = floor f.
- clrup  in  NFLOORS  per-floor clear of the UP request.
- clrdn  in  NFLOORS  per-floor clear of the DOWN request.
- curfloor  in  FW  current lift floor.
- upreq  out  NFLOORS  per-floor UP request (registered).
- dnreq  out  NFLOORS  per-floor DOWN request (registered).
- req_above  out  1  any request at a floor > curfloor.
- req_below  out  1  any request at a floor < curfloor.
- req_here_up  out  1  upreq[curfloor].
- req_here_dn  out  1  dnreq[curfloor].
- stale  out  NFLOORS  per-floor age counter at AGE_MAX.
- oldest_vld  out  1  at least one floor has a request pending.
- oldest_floor  out  FW  index of the floor with the largest age.

## Operation
- Per-floor state is {up,dn}, with encodings OFF=00, UP=10, DN=01, BOTH=11.
- On reset, all states are OFF, all ages are 0, and every output is 0.
- State is evaluated only when slowref=1; when slowref=0 the state holds and every input is ignored. Upstream must hold pbpulse and the clears across a slowref cycle.
- Priority per floor per tick: clears first, then the press. The press is applied only if no clear is active for that floor and hall_en=1.
- Clears for middle floors (0 < f < NFLOORS-1):
  - clrup clears bit up.
  - clrdn clears bit dn.
  - clrup and clrdn together clear both bits (BOTH -> OFF).
  - A clear on an already-clear bit is a no-op.
- Press transitions for middle floors: OFF->UP, UP->DN, DN->BOTH, BOTH->BOTH.
- Floor 0 accepts UP only: OFF->UP on press, UP holds on press. The dn bit is never set there.
- Floor NFLOORS-1 accepts DOWN only: OFF->DN on press, DN holds on press. The up bit is never set there.
- Any illegal or unreachable encoding returns to OFF on the next slowref tick.
- Age counters:
  - On a slowref tick, age[f] increments while floor f's state (before update) is non-OFF, saturating at AGE_MAX.
  - age[f] is forced to 0 on any tick where the next state is OFF.
  - A floor leaving OFF starts at age 0.
- stale[f] = (age[f]==AGE_MAX).
- oldest_floor is the pending floor with the maximum age; ties go to the lowest index. When no floor is pending, oldest_floor=0 and oldest_vld=0.
- Aggregates are combinational from the registered state and curfloor. If curfloor >= NFLOORS, req_above, req_below, req_here_up and req_here_dn are all 0.

## Timing
- State and age update on the rising clk edge of a cycle with slowref=1. upreq, dnreq and stale are visible the cycle after that edge.
- Aggregate and oldest outputs follow the registered state with zero added latency. They respond to curfloor changes in the same cycle.
- Latency from a press to the request output is 1 clk after the sampling slowref cycle.
- A clear and a press in the same tick on the same floor: the clear wins and the press is dropped.
- Asserting resetb low mid-operation forces all state, ages and outputs to 0 immediately (asynchronous), independent of clk.
- The age counter does not wrap: it stays at AGE_MAX until the floor returns to OFF.

## Test plan
- Press cycling, NFLOORS=4, floor 1: four presses on four separate slowref ticks -> {upreq[1],dnreq[1]} = 10, 01, 11, 11. Each value appears 1 clk after its tick.
- End floors: three presses on floor 0 -> upreq[0]=1 and dnreq[0]=0 throughout. Three presses on floor 3 -> dnreq[3]=1 and upreq[3]=0 throughout.
- Clear precedence: floor 2 in BOTH; clrup+clrdn+pbpulse in one tick -> OFF. From BOTH, clrup alone -> DN; from BOTH, clrdn alone -> UP. A press with slowref=0 -> no change.
- Aggregates, curfloor=1: floor 3 DN and floor 0 UP pending -> req_above=1, req_below=1, req_here_up=0. Setting curfloor=5 (FW=3 build) -> all four aggregates 0.
- Ageing, AGEW=3: floor 2 pressed, then 7 ticks later floor 1 pressed -> oldest_floor=2. After the 8th tick, stale[2]=1 and age[2] holds at 7. Clearing floor 2 -> stale[2]=0 and oldest_floor=1.
- Reset and disable: hall_en=0 with presses on all floors -> no requests. Asserting resetb low mid-pattern -> all outputs 0 in the same cycle. Releasing resetb -> OFF everywhere.
